beep_sequencer: RTL and testbench
=================================

# beep_sequencer

Controller for the clock's piezo tone generator, which toggles a fixed-frequency square wave whenever its enable input is high. This block owns that enable: it arbitrates between three beep requesters (alarm, hourly chime, key click) and sequences each one's on/off cadence in millisecond units. It sits between the timekeeping/alarm-compare logic and the tone generator, whose `en` input is driven directly by `beep_en`.

## Interface
- `TICK_DIV`, 48000: clock cycles per 1 ms tick (48 MHz system clock); set to 4 in simulation.
- `KEY_MS`, 30: key-click beep length, ms.
- `CHIME_ON_MS`, 200: chime on time, ms. Chime off time is the same value.
- `ALARM_ON_MS`, 100: alarm burst on time, ms. Burst off time is the same value.
- `ALARM_GAP_MS`, 500: silence after each group of 4 alarm bursts, ms.
- `ALARM_TIMEOUT_MS`, 60000: auto-mute limit for a continuous alarm, ms.

Ports:
- `clk` in 1: system clock, 48 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `alarm_req` in 1: level; high while the alarm time matches or is latched.
- `chime_req` in 1: single-cycle pulse; requests an hourly chime.
- `key_req` in 1: single-cycle pulse; requests a key click.
- `stop` in 1: single-cycle pulse; user silences the alarm.
- `beep_en` out 1: registered; enable for the tone generator.
- `busy` out 1: registered; high in any state other than IDLE.
- `active_src` out 2: registered; 0 = none, 1 = key, 2 = chime, 3 = alarm.
- `alarm_muted` out 1: registered; alarm silenced by `stop` or by timeout.

## Operation
- States: IDLE, ON, OFF, GAP. Counters: `ms_cnt` (ms elapsed in the current phase), `burst_cnt` (0–3), `alarm_ms` (timeout accumulator, saturating).
- Pending flags `chime_pend` and `key_pend` are set by their request pulses. A flag is cleared when its sequence starts or completes. A repeat pulse while the flag is already set is absorbed.
- Priority: alarm > chime > key.
  - An alarm (`alarm_req` high and `alarm_muted` low) preempts any running chime or key sequence immediately. The preempted request is dropped; its pending flag is cleared.
  - A chime does not preempt a key click. It waits in `chime_pend`.
- Key sequence: ON for `KEY_MS`, then IDLE.
- Chime sequence: ON, OFF, ON (`CHIME_ON_MS` each), then IDLE.
- Alarm sequence:
  - Repeats (ON `ALARM_ON_MS`, OFF `ALARM_ON_MS`) four times, with the fourth OFF replaced by GAP (`ALARM_GAP_MS`). Then back to ON.
  - Continues while `alarm_req` is high and `alarm_muted` is low.
  - When `alarm_req` drops, or a `stop` pulse arrives, the block goes to IDLE on the next cycle and `beep_en` drops in the same transition.
- `alarm_muted`:
  - Set by a `stop` pulse while `alarm_req` is high.
  - Set when `alarm_ms` reaches `ALARM_TIMEOUT_MS`.
  - Cleared only when `alarm_req` is low.
- `beep_en` is 1 exactly in state ON.

## Timing
- Reset values: state IDLE, all counters 0, pending flags 0, `beep_en` = 0, `busy` = 0, `active_src` = 0, `alarm_muted` = 0.
- The ms prescaler is cleared on every IDLE→ON transition and on preemption, so every phase lasts exactly N × `TICK_DIV` cycles.
- Latency: a request sampled in IDLE at edge k gives `beep_en` = 1 from edge k+1.
- Phase transitions happen on the tick that completes the phase, so the next phase starts on the following edge.
- Simultaneous `chime_req` and `key_req` in IDLE: the chime starts and `key_pend` is kept. The key click runs after the chime finishes, with one IDLE cycle between sequences.
- `stop` together with a rising `alarm_req`: the alarm is muted and `beep_en` never rises.
- `stop` with no alarm active: ignored.
- `alarm_ms` counts ms while `alarm_req` is high and is cleared while `alarm_req` is low. It does not wrap.
- Reset asserted mid-sequence: all outputs return asynchronously to their reset values.

## Structure
- Package `beep_pkg` holds:
  - the state encoding (IDLE/ON/OFF/GAP);
  - the `active_src` codes;
  - the constant `ALARM_BURSTS` = 4.
- Sub-module `ms_tick_gen`: a `TICK_DIV` prescaler with a synchronous clear, producing a 1-cycle `tick` pulse. The sequencer FSM and the arbiter stay in `beep_sequencer`.

## Test plan
All scenarios use `TICK_DIV` = 4.
- Key click: `key_req` pulse in IDLE → `beep_en` high for exactly 120 cycles starting the next cycle, `active_src` = 1, then `busy` drops.
- Chime: `chime_req` pulse → `beep_en` high 800 cycles, low 800 cycles, high 800 cycles, then IDLE. `active_src` = 2 throughout.
- Preemption: `alarm_req` rises 100 cycles into a chime → `beep_en` restarts an ON phase of 400 cycles on the next cycle with `active_src` = 3, and the chime is not resumed.
- Alarm cadence: hold `alarm_req` high → 4 × (400 on / 400 off) with the fourth off lasting 2000 cycles, then the pattern repeats.
- Stop and mute:
  - A `stop` pulse mid-ON → `beep_en` = 0 next cycle, `alarm_muted` = 1, and the block stays silent while `alarm_req` is high.
  - Dropping `alarm_req` clears `alarm_muted`.
  - With `ALARM_TIMEOUT_MS` = 10, `alarm_muted` sets after 40 cycles.
- Queueing and reset: simultaneous `chime_req` and `key_req` → the chime runs, then the key click, after one IDLE cycle. `rst_n` low during ON → `beep_en` = 0 immediately.

Source files
------------

// File: rtl/beep_pkg.sv
// Shared types and constants for the piezo beep sequencer.
package beep_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_KEY   = 2'd1,
    SRC_CHIME = 2'd2,
    SRC_ALARM = 2'd3
  } src_t;

  localparam int unsigned ALARM_BURSTS = 4;

endpackage

// File: rtl/beep_if.sv
// Request/status bundle between the timekeeping logic and the beep sequencer.
interface beep_if;
  // No valid/ready handshake: alarm_req is a level; chime_req, key_req and stop
  // are single-cycle pulses captured on the next clock edge. All outputs are registered.
  logic       alarm_req;
  logic       chime_req;
  logic       key_req;
  logic       stop;
  logic       beep_en;
  logic       busy;
  logic [1:0] active_src;
  logic       alarm_muted;

  modport master (
    output alarm_req, chime_req, key_req, stop,
    input  beep_en, busy, active_src, alarm_muted
  );

  modport slave (
    input  alarm_req, chime_req, key_req, stop,
    output beep_en, busy, active_src, alarm_muted
  );
endinterface

// File: rtl/beep_sequencer_ms_tick_gen.sv
// Millisecond prescaler: one-cycle o_tick every TICK_DIV clocks, restartable via i_clr.
module ms_tick_gen #(
  parameter int unsigned TICK_DIV = 48000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_tick
);
  localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST);
endmodule

// File: rtl/beep_sequencer.sv
// Arbitrates alarm/chime/key beep requests and sequences the tone-generator enable.
module beep_sequencer
  import beep_pkg::*;
#(
  parameter int unsigned TICK_DIV         = 48000,
  parameter int unsigned KEY_MS           = 30,
  parameter int unsigned CHIME_ON_MS      = 200,
  parameter int unsigned ALARM_ON_MS      = 100,
  parameter int unsigned ALARM_GAP_MS     = 500,
  parameter int unsigned ALARM_TIMEOUT_MS = 60000
) (
  input  logic   clk,
  input  logic   rst_n,
  beep_if.slave  bus,
  output state_t o_dbg_state
);
  localparam logic [1:0]  LAST_BURST = 2'(ALARM_BURSTS - 1);
  localparam logic [31:0] TIMEOUT    = 32'(ALARM_TIMEOUT_MS);

  state_t      r_state, w_state_nxt;
  src_t        r_src, w_src_nxt;
  logic [31:0] r_ms_cnt, w_ms_nxt;
  logic [1:0]  r_burst, w_burst_nxt;
  logic [31:0] r_alarm_ms, w_alarm_ms_nxt;
  logic        r_chime_pend, w_chime_pend_nxt;
  logic        r_key_pend, w_key_pend_nxt;
  logic        r_muted, w_muted_nxt;
  logic        r_alarm_req_q;
  logic        r_beep_en, r_busy;
  logic        w_tick, w_clr, w_alarm_go, w_cp, w_kp, w_phase_done;
  logic [31:0] w_phase_len;

  function automatic logic [31:0] phase_len(src_t s, state_t st);
    logic [31:0] len;
    len = 32'd1;
    case (s)
      SRC_KEY:   len = 32'(KEY_MS);
      SRC_CHIME: len = 32'(CHIME_ON_MS);
      SRC_ALARM: len = (st == S_GAP) ? 32'(ALARM_GAP_MS) : 32'(ALARM_ON_MS);
      default:   len = 32'd1;
    endcase
    return len;
  endfunction

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  // Timeout accounting starts the cycle after alarm_req is first seen, so the
  // free-running prescaler phase before the alarm starts is never counted.
  always_comb begin
    w_alarm_ms_nxt = r_alarm_ms;
    if (!bus.alarm_req) begin
      w_alarm_ms_nxt = '0;
    end else if (w_tick && r_alarm_req_q && (r_alarm_ms != TIMEOUT)) begin
      w_alarm_ms_nxt = r_alarm_ms + 32'd1;
    end
    w_muted_nxt = bus.alarm_req &&
                  (r_muted || bus.stop || (w_alarm_ms_nxt == TIMEOUT));
    w_alarm_go  = bus.alarm_req && !w_muted_nxt;
    w_cp        = r_chime_pend | bus.chime_req;
    w_kp        = r_key_pend | bus.key_req;
    w_phase_len  = phase_len(r_src, r_state);
    w_phase_done = w_tick && ((r_ms_cnt + 32'd1) == w_phase_len);
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_src_nxt        = r_src;
    w_ms_nxt         = w_tick ? (r_ms_cnt + 32'd1) : r_ms_cnt;
    w_burst_nxt      = r_burst;
    w_chime_pend_nxt = w_cp;
    w_key_pend_nxt   = w_kp;
    w_clr            = 1'b0;
    if (w_alarm_go && (r_src != SRC_ALARM)) begin
      w_state_nxt = S_ON;
      w_src_nxt   = SRC_ALARM;
      w_ms_nxt    = '0;
      w_burst_nxt = '0;
      w_clr       = 1'b1;
      if (r_src == SRC_CHIME) w_chime_pend_nxt = 1'b0;
      if (r_src == SRC_KEY)   w_key_pend_nxt   = 1'b0;
    end else if ((r_src == SRC_ALARM) && !w_alarm_go) begin
      w_state_nxt = S_IDLE;
      w_src_nxt   = SRC_NONE;
      w_ms_nxt    = '0;
      w_burst_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_ms_nxt = '0;
          if (w_cp) begin
            w_state_nxt      = S_ON;
            w_src_nxt        = SRC_CHIME;
            w_chime_pend_nxt = 1'b0;
            w_burst_nxt      = '0;
            w_clr            = 1'b1;
          end else if (w_kp) begin
            w_state_nxt    = S_ON;
            w_src_nxt      = SRC_KEY;
            w_key_pend_nxt = 1'b0;
            w_burst_nxt    = '0;
            w_clr          = 1'b1;
          end
        end
        S_ON: begin
          if (w_phase_done) begin
            w_ms_nxt = '0;
            case (r_src)
              SRC_CHIME: begin
                if (r_burst == 2'd1) begin
                  w_state_nxt      = S_IDLE;
                  w_src_nxt        = SRC_NONE;
                  w_burst_nxt      = '0;
                  w_chime_pend_nxt = 1'b0;
                end else begin
                  w_state_nxt = S_OFF;
                end
              end
              SRC_ALARM: w_state_nxt = (r_burst == LAST_BURST) ? S_GAP : S_OFF;
              default: begin
                w_state_nxt    = S_IDLE;
                w_src_nxt      = SRC_NONE;
                w_burst_nxt    = '0;
                w_key_pend_nxt = 1'b0;
              end
            endcase
          end
        end
        S_OFF: begin
          if (w_phase_done) begin
            w_ms_nxt    = '0;
            w_state_nxt = S_ON;
            w_burst_nxt = r_burst + 2'd1;
          end
        end
        S_GAP: begin
          if (w_phase_done) begin
            w_ms_nxt    = '0;
            w_state_nxt = S_ON;
            w_burst_nxt = '0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_src         <= SRC_NONE;
      r_ms_cnt      <= '0;
      r_burst       <= '0;
      r_alarm_ms    <= '0;
      r_chime_pend  <= 1'b0;
      r_key_pend    <= 1'b0;
      r_muted       <= 1'b0;
      r_alarm_req_q <= 1'b0;
      r_beep_en     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_src         <= w_src_nxt;
      r_ms_cnt      <= w_ms_nxt;
      r_burst       <= w_burst_nxt;
      r_alarm_ms    <= w_alarm_ms_nxt;
      r_chime_pend  <= w_chime_pend_nxt;
      r_key_pend    <= w_key_pend_nxt;
      r_muted       <= w_muted_nxt;
      r_alarm_req_q <= bus.alarm_req;
      r_beep_en     <= (w_state_nxt == S_ON);
      r_busy        <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.beep_en     = r_beep_en;
  assign bus.busy        = r_busy;
  assign bus.active_src  = r_src;
  assign bus.alarm_muted = r_muted;
  assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_beep_sequencer.sv
// Directed bench for beep_sequencer with TICK_DIV = 4; a second instance uses a 10 ms alarm timeout.
module tb_beep_sequencer;
  import beep_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t dbg_state, dbg_state2;
  int     n_checks;
  int     n_errors;

  beep_if bus ();
  beep_if bus2 ();

  beep_sequencer #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  beep_sequencer #(.TICK_DIV(4), .ALARM_TIMEOUT_MS(10)) dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus2),
    .o_dbg_state (dbg_state2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts consecutive sampled cycles where beep_en equals lvl (bounded).
  task automatic measure(input logic sel, input logic lvl, output int len);
    len = 0;
    while (((sel ? bus2.beep_en : bus.beep_en) == lvl) && (len < 5000)) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_key();
    bus.key_req = 1'b1; @(negedge clk); bus.key_req = 1'b0;
  endtask

  task automatic pulse_chime();
    bus.chime_req = 1'b1; @(negedge clk); bus.chime_req = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1; @(negedge clk); bus.stop = 1'b0;
  endtask

  initial begin
    int len;
    int hi;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.alarm_req  = 1'b0; bus.chime_req  = 1'b0; bus.key_req  = 1'b0; bus.stop  = 1'b0;
    bus2.alarm_req = 1'b0; bus2.chime_req = 1'b0; bus2.key_req = 1'b0; bus2.stop = 1'b0;
    tick_n(3);
    check_eq("rst_beep_en", 32'(bus.beep_en), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_src", 32'(bus.active_src), 32'd0);
    check_eq("rst_muted", 32'(bus.alarm_muted), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst_n = 1'b1;
    tick_n(5);

    // key click: 30 ms
    pulse_key();
    check_eq("key_src", 32'(bus.active_src), 32'd1);
    check_eq("key_busy", 32'(bus.busy), 32'd1);
    measure(1'b0, 1'b1, len);
    check_eq("key_on_len", 32'(len), 32'd120);
    check_eq("key_done_busy", 32'(bus.busy), 32'd0);
    tick_n(10);

    // chime: on/off/on 200 ms each
    pulse_chime();
    check_eq("chime_src", 32'(bus.active_src), 32'd2);
    measure(1'b0, 1'b1, len);
    check_eq("chime_on1", 32'(len), 32'd800);
    check_eq("chime_off_src", 32'(bus.active_src), 32'd2);
    measure(1'b0, 1'b0, len);
    check_eq("chime_off", 32'(len), 32'd800);
    measure(1'b0, 1'b1, len);
    check_eq("chime_on2", 32'(len), 32'd800);
    check_eq("chime_done_busy", 32'(bus.busy), 32'd0);
    tick_n(10);

    // alarm preempts a chime 100 cycles in, then runs its cadence
    pulse_chime();
    tick_n(99);
    bus.alarm_req = 1'b1;
    @(negedge clk);
    check_eq("preempt_src", 32'(bus.active_src), 32'd3);
    check_eq("preempt_beep", 32'(bus.beep_en), 32'd1);
    for (int b = 0; b < 4; b++) begin
      measure(1'b0, 1'b1, len);
      check_eq($sformatf("alarm_on%0d", b), 32'(len), 32'd400);
      measure(1'b0, 1'b0, len);
      check_eq($sformatf("alarm_off%0d", b), 32'(len), (b == 3) ? 32'd2000 : 32'd400);
    end
    check_eq("alarm_repeat_src", 32'(bus.active_src), 32'd3);
    tick_n(50);
    check_eq("alarm_repeat_on", 32'(bus.beep_en), 32'd1);
    pulse_stop();
    check_eq("stop_beep", 32'(bus.beep_en), 32'd0);
    check_eq("stop_muted", 32'(bus.alarm_muted), 32'd1);
    check_eq("stop_busy", 32'(bus.busy), 32'd0);
    hi = 0;
    repeat (500) begin
      @(negedge clk);
      if (bus.beep_en) hi++;
    end
    check_eq("muted_silent", 32'(hi), 32'd0);
    bus.alarm_req = 1'b0;
    @(negedge clk);
    check_eq("unmute", 32'(bus.alarm_muted), 32'd0);
    tick_n(5);
    check_eq("chime_not_resumed", 32'(bus.busy), 32'd0);

    // stop arriving with a rising alarm_req
    bus.alarm_req = 1'b1;
    pulse_stop();
    check_eq("stop_rise_muted", 32'(bus.alarm_muted), 32'd1);
    hi = 0;
    repeat (100) begin
      if (bus.beep_en) hi++;
      @(negedge clk);
    end
    check_eq("stop_rise_silent", 32'(hi), 32'd0);
    bus.alarm_req = 1'b0;
    tick_n(2);

    // stop with no alarm is ignored
    pulse_stop();
    check_eq("idle_stop_muted", 32'(bus.alarm_muted), 32'd0);
    check_eq("idle_stop_busy", 32'(bus.busy), 32'd0);

    // simultaneous chime + key: chime, one IDLE cycle, then key
    bus.chime_req = 1'b1; bus.key_req = 1'b1;
    @(negedge clk);
    bus.chime_req = 1'b0; bus.key_req = 1'b0;
    check_eq("queue_src_chime", 32'(bus.active_src), 32'd2);
    measure(1'b0, 1'b1, len);
    measure(1'b0, 1'b0, len);
    measure(1'b0, 1'b1, len);
    check_eq("queue_chime_on2", 32'(len), 32'd800);
    measure(1'b0, 1'b0, len);
    check_eq("queue_idle_gap", 32'(len), 32'd1);
    check_eq("queue_src_key", 32'(bus.active_src), 32'd1);
    measure(1'b0, 1'b1, len);
    check_eq("queue_key_len", 32'(len), 32'd120);
    tick_n(5);

    // asynchronous reset in the middle of ON
    pulse_key();
    tick_n(10);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_beep", 32'(bus.beep_en), 32'd0);
    check_eq("async_rst_src", 32'(bus.active_src), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick_n(3);

    // 10 ms timeout on the second instance
    bus2.alarm_req = 1'b1;
    @(negedge clk);
    measure(1'b1, 1'b1, len);
    check_eq("timeout_on_len", 32'(len), 32'd40);
    check_eq("timeout_muted", 32'(bus2.alarm_muted), 32'd1);
    tick_n(20);
    check_eq("timeout_silent", 32'(bus2.beep_en), 32'd0);
    bus2.alarm_req = 1'b0;
    @(negedge clk);
    check_eq("timeout_unmute", 32'(bus2.alarm_muted), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
